// File: rtl/ahb3lite_cmd_master_pkg.sv
// AHB3-Lite encodings and the address-phase command record shared by the command master and its bench.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HWORD   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Field widths of the command record; the master's bus parameters must match these.
  localparam int AHB_ADDR_W = 16;
  localparam int AHB_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb3lite_cmd_master_if.sv
// Command/response handshake plus the AHB3-Lite master bus; master = the command master, slave = its environment.
interface ahb3lite_cmd_master_if #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32,
  parameter int ERRCNT_W   = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [HADDR_SIZE-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [HDATA_SIZE-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_write;
  logic [HDATA_SIZE-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  busy;
  logic [ERRCNT_W-1:0]   err_count;
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HREADY;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HREADY, HRDATA, HRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy, err_count,
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HREADY, HRDATA, HRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy, err_count,
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/ahb3lite_cmd_master.sv
// Issues commands as pipelined AHB3-Lite NONSEQ SINGLE transfers; response 3 cycles after acceptance at zero wait.
// cmd_ready falls only while a held address phase sees HREADY=0; responses cannot be backpressured.
module ahb3lite_cmd_master
  import ahb3lite_pkg::*;
#(
  parameter int         HADDR_SIZE = 16,
  parameter int         HDATA_SIZE = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter int         ERRCNT_W   = 8
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb3lite_cmd_master_if.master bus
);

  logic                  ap_vld_q, ap_vld_d;
  ahb_cmd_t              ap_q, ap_d;
  logic                  dp_vld_q, dp_vld_d;
  logic                  dp_write_q, dp_write_d;
  logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

  logic                  cmd_ready;
  logic                  cmd_acc;
  logic [2:0]            size_n;
  logic [HADDR_SIZE-1:0] addr_al;

  always_comb begin
    cmd_ready   = !HRESET && (!ap_vld_q || bus.HREADY);
    cmd_acc     = bus.cmd_valid && cmd_ready;
    size_n      = (bus.cmd_size > HSIZE_WORD) ? HSIZE_WORD : bus.cmd_size;
    addr_al     = bus.cmd_addr;
    if (size_n == HSIZE_HWORD) addr_al[0] = 1'b0;
    else if (size_n == HSIZE_WORD) addr_al[1:0] = 2'b00;

    ap_vld_d    = ap_vld_q;
    ap_d        = ap_q;
    dp_vld_d    = dp_vld_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    rsp_vld_d   = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    err_count_d = err_count_q;

    // Pipeline advances only on HREADY; a stalled beat keeps AP, DP and HWDATA frozen.
    if (bus.HREADY) begin
      dp_vld_d   = ap_vld_q;
      dp_write_d = ap_q.write;
      ap_vld_d   = 1'b0;
      if (ap_vld_q && ap_q.write) hwdata_d = ap_q.wdata;
      if (dp_vld_q) begin
        rsp_vld_d   = 1'b1;
        rsp_write_d = dp_write_q;
        rsp_rdata_d = dp_write_q ? '0 : bus.HRDATA;
        rsp_error_d = (bus.HRESP == HRESP_ERROR);
      end
    end

    if (cmd_acc) begin
      ap_vld_d = 1'b1;
      ap_d     = '{write: bus.cmd_write, addr: addr_al, size: size_n, wdata: bus.cmd_wdata};
    end

    if (rsp_error_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_vld_q    <= 1'b0;
      ap_q        <= '0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      ap_vld_q    <= ap_vld_d;
      ap_q        <= ap_d;
      dp_vld_q    <= dp_vld_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.busy      = ap_vld_q || dp_vld_q;
  assign bus.err_count = err_count_q;
  assign bus.HTRANS    = ap_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HSEL      = ap_vld_q;
  assign bus.HADDR     = ap_q.addr;
  assign bus.HWRITE    = ap_q.write;
  assign bus.HSIZE     = ap_q.size;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Bench for ahb3lite_cmd_master: a small memory slave plus directed and randomized scenarios scored against an in-order model.
module tb_ahb3lite_cmd_master;
  import ahb3lite_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb3lite_cmd_master_if #(.HADDR_SIZE(16), .HDATA_SIZE(32), .ERRCNT_W(8)) bus ();

  ahb3lite_cmd_master #(
    .HADDR_SIZE(16), .HDATA_SIZE(32), .HPROT_VAL(4'b0011), .ERRCNT_W(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] lo, input logic [2:0] sz);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sz >= 3'd2 || (sz == 3'd1 && (b / 2) == int'(lo[1])) || (sz == 3'd0 && b == int'(lo)))
        r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory slave: captures address phases, commits OKAY writes, returns words during read data phases.
  logic [31:0] mem [64];
  logic        s_vld, s_write;
  logic [15:0] s_addr;
  logic [2:0]  s_size;
  assign bus.HRDATA = (s_vld && !s_write) ? mem[s_addr[7:2]] : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      s_vld <= 1'b0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
    end else if (bus.HREADY) begin
      if (s_vld && s_write && !bus.HRESP)
        mem[s_addr[7:2]] <= merge(mem[s_addr[7:2]], bus.HWDATA, s_addr[1:0], s_size);
      s_vld   <= (bus.HTRANS == HTRANS_NONSEQ);
      s_write <= bus.HWRITE;
      s_addr  <= bus.HADDR;
      s_size  <= bus.HSIZE;
    end
  end

  typedef struct { logic write; logic [31:0] rdata; int acc; } exp_rsp_t;
  typedef struct { logic write; logic [15:0] addr; logic [2:0] size; } exp_ap_t;
  exp_rsp_t    exp_q[$];
  exp_ap_t     ap_pend[$];
  logic [31:0] refmem [64];

  task automatic put_cmd(input logic wr, input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_size  = sz;
    bus.cmd_wdata = wd;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRESP = 1'b0;
    put_cmd(1'b1, 16'h0100, 3'd2, 32'h12345678);
    repeat (3) begin
      @(negedge HCLK); #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.cmd_ready); end
      checks++; if (bus.HTRANS !== HTRANS_IDLE) begin failures++; $display("FAIL reset_htrans got=%b exp=00", bus.HTRANS); end
      checks++; if (bus.err_count !== 8'h00) begin failures++; $display("FAIL reset_errcnt got=%h exp=00", bus.err_count); end
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=0", bus.rsp_valid); end
      checks++; if (bus.busy !== 1'b0 || bus.HSEL !== 1'b0) begin failures++; $display("FAIL reset_busy_hsel got=%b%b exp=00", bus.busy, bus.HSEL); end
      checks++; if (bus.HADDR !== 16'h0 || bus.HWDATA !== 32'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", bus.HADDR, bus.HWDATA); end
    end
    checks++; if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011 || bus.HMASTLOCK !== 1'b0) begin failures++; $display("FAIL const_ctrl got=%b/%b/%b exp=000/0011/0", bus.HBURST, bus.HPROT, bus.HMASTLOCK); end
    @(negedge HCLK);
    HRESET = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge HCLK); put_cmd(1'b1, 16'h0010, 3'd2, 32'hDEADBEEF); #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", bus.cmd_ready); end
    @(negedge HCLK); put_cmd(1'b0, 16'h0010, 3'd2, 32'h0); #1;
    checks++; if (bus.HTRANS !== HTRANS_NONSEQ || bus.HADDR !== 16'h0010 || bus.HWRITE !== 1'b1) begin failures++; $display("FAIL wr_aphase got=%b/%h/%b exp=10/0010/1", bus.HTRANS, bus.HADDR, bus.HWRITE); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%b exp=1", bus.cmd_ready); end
    @(negedge HCLK); bus.cmd_valid = 1'b0; #1;
    checks++; if (bus.HTRANS !== HTRANS_NONSEQ || bus.HWRITE !== 1'b0) begin failures++; $display("FAIL rd_aphase got=%b/%b exp=10/0", bus.HTRANS, bus.HWRITE); end
    checks++; if (bus.HWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hwdata got=%h exp=deadbeef", bus.HWDATA); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL early_rsp got=%b exp=0", bus.rsp_valid); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/1/0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata); end
    checks++; if (bus.HTRANS !== HTRANS_IDLE || bus.busy !== 1'b1) begin failures++; $display("FAIL idle_after got=%b/%b exp=00/1", bus.HTRANS, bus.busy); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_error !== 1'b0) begin failures++; $display("FAIL rd_rsp got=%b/%b/%h/%b exp=1/0/deadbeef/0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_error); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL wr_rd_drain got=%b/%b exp=0/0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_wait_states();
    @(negedge HCLK); put_cmd(1'b0, 16'h0020, 3'd2, 32'h0); #1;
    @(negedge HCLK); put_cmd(1'b1, 16'h0024, 3'd2, 32'h11112222); #1;
    for (int s = 0; s < 2; s++) begin
      @(negedge HCLK); bus.HREADY = 1'b0; put_cmd(1'b0, 16'h0024, 3'd2, 32'h0); #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL ws_ready cyc=%0d got=%b exp=0", s, bus.cmd_ready); end
      checks++; if (bus.HTRANS !== HTRANS_NONSEQ || bus.HADDR !== 16'h0024 || bus.HWRITE !== 1'b1) begin failures++; $display("FAIL ws_hold cyc=%0d got=%b/%h/%b exp=10/0024/1", s, bus.HTRANS, bus.HADDR, bus.HWRITE); end
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL ws_rsp cyc=%0d got=%b exp=0", s, bus.rsp_valid); end
    end
    @(negedge HCLK); bus.HREADY = 1'b1; #1;
    checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL ws_release got=%b/%b exp=1/0", bus.cmd_ready, bus.rsp_valid); end
    @(negedge HCLK); bus.cmd_valid = 1'b0; #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'hC0DE0008) begin failures++; $display("FAIL ws_rd_rsp got=%b/%b/%h exp=1/0/c0de0008", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata); end
    checks++; if (bus.HTRANS !== HTRANS_NONSEQ || bus.HWRITE !== 1'b0) begin failures++; $display("FAIL ws_third_ap got=%b/%b exp=10/0", bus.HTRANS, bus.HWRITE); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1) begin failures++; $display("FAIL ws_wr_rsp got=%b/%b exp=1/1", bus.rsp_valid, bus.rsp_write); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h11112222) begin failures++; $display("FAIL ws_readback got=%b/%h exp=1/11112222", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge HCLK); #1;
  endtask

  task automatic test_alignment();
    @(negedge HCLK); put_cmd(1'b1, 16'h0013, 3'd1, 32'hABCD0000); #1;
    @(negedge HCLK); put_cmd(1'b0, 16'h0037, 3'b101, 32'h0); #1;
    checks++; if (bus.HADDR !== 16'h0012 || bus.HSIZE !== 3'b001) begin failures++; $display("FAIL align_half got=%h/%b exp=0012/001", bus.HADDR, bus.HSIZE); end
    @(negedge HCLK); bus.cmd_valid = 1'b0; #1;
    checks++; if (bus.HADDR !== 16'h0034 || bus.HSIZE !== 3'b010) begin failures++; $display("FAIL align_word got=%h/%b exp=0034/010", bus.HADDR, bus.HSIZE); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1) begin failures++; $display("FAIL align_wr_rsp got=%b/%b exp=1/1", bus.rsp_valid, bus.rsp_write); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hC0DE000D) begin failures++; $display("FAIL align_rd_rsp got=%b/%h exp=1/c0de000d", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge HCLK); #1;
  endtask

  // Streams random commands; the model tracks the pending address phase and in-order responses.
  task automatic run_stream(input int n, input bit b2b);
    exp_rsp_t er;
    exp_ap_t  ea;
    logic [2:0]  sz;
    logic [15:0] a;
    for (int c = 0; c < n + 12; c++) begin
      @(negedge HCLK);
      if (c < n) begin
        bus.cmd_valid = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = 16'h0080 | 16'($urandom_range(0, 127));
        bus.cmd_size  = 3'($urandom_range(0, 7));
        bus.cmd_wdata = $urandom;
        bus.HREADY    = b2b ? 1'b1 : ($urandom_range(0, 4) != 0);
      end else begin
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b1;
      end
      #1;
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stream_unexpected_rsp cyc=%0d got=1 exp=0", c); end
        else begin
          er = exp_q.pop_front();
          if (bus.rsp_write !== er.write || bus.rsp_rdata !== er.rdata || bus.rsp_error !== 1'b0) begin failures++; $display("FAIL stream_rsp cyc=%0d got=%b/%h/%b exp=%b/%h/0", c, bus.rsp_write, bus.rsp_rdata, bus.rsp_error, er.write, er.rdata); end
          if (b2b) begin
            checks++; if (c - er.acc != 3) begin failures++; $display("FAIL stream_latency got=%0d exp=3", c - er.acc); end
          end
        end
      end
      checks++; if (bus.cmd_ready !== (ap_pend.size() == 0 || bus.HREADY)) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", c, bus.cmd_ready, (ap_pend.size() == 0 || bus.HREADY)); end
      checks++; if ((bus.HTRANS == HTRANS_NONSEQ) !== (ap_pend.size() != 0)) begin failures++; $display("FAIL stream_htrans cyc=%0d got=%b exp_pending=%0d", c, bus.HTRANS, ap_pend.size()); end
      if (ap_pend.size() != 0) begin
        ea = ap_pend[0];
        checks++; if (bus.HADDR !== ea.addr || bus.HSIZE !== ea.size || bus.HWRITE !== ea.write) begin failures++; $display("FAIL stream_aphase cyc=%0d got=%h/%b/%b exp=%h/%b/%b", c, bus.HADDR, bus.HSIZE, bus.HWRITE, ea.addr, ea.size, ea.write); end
        if (bus.HREADY) void'(ap_pend.pop_front());
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        sz = (bus.cmd_size > 3'd2) ? 3'd2 : bus.cmd_size;
        a  = 16'((int'(bus.cmd_addr) / (1 << sz)) * (1 << sz));
        ap_pend.push_back('{write: bus.cmd_write, addr: a, size: sz});
        if (bus.cmd_write) refmem[a[7:2]] = merge(refmem[a[7:2]], bus.cmd_wdata, a[1:0], sz);
        exp_q.push_back('{write: bus.cmd_write, rdata: bus.cmd_write ? 32'h0 : refmem[a[7:2]], acc: c});
      end
    end
    checks++; if (exp_q.size() != 0 || ap_pend.size() != 0) begin failures++; $display("FAIL stream_drain got=%0d/%0d exp=0/0", exp_q.size(), ap_pend.size()); end
    exp_q.delete();
    ap_pend.delete();
  endtask

  task automatic test_back_to_back();
    run_stream(60, 1'b1);
  endtask

  task automatic test_random();
    run_stream(400, 1'b0);
  endtask

  task automatic test_error();
    int exp_err;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    @(negedge HCLK); put_cmd(1'b1, 16'h0040, 3'd2, 32'h5555AAAA); #1;
    @(negedge HCLK); put_cmd(1'b0, 16'h0044, 3'd2, 32'h0); #1;
    checks++; if (bus.err_count !== 8'h00) begin failures++; $display("FAIL err_pre got=%h exp=00", bus.err_count); end
    @(negedge HCLK); bus.cmd_valid = 1'b0; bus.HREADY = 1'b0; bus.HRESP = 1'b1; #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL err_ready got=%b exp=0", bus.cmd_ready); end
    @(negedge HCLK); bus.HREADY = 1'b1; #1;
    checks++; if (bus.HTRANS !== HTRANS_NONSEQ || bus.HADDR !== 16'h0044 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL err_ap_kept got=%b/%h/%b exp=10/0044/0", bus.HTRANS, bus.HADDR, bus.rsp_valid); end
    @(negedge HCLK); bus.HRESP = 1'b0; #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1 || bus.rsp_error !== 1'b1) begin failures++; $display("FAIL err_wr_rsp got=%b/%b/%b exp=1/1/1", bus.rsp_valid, bus.rsp_write, bus.rsp_error); end
    @(negedge HCLK); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'hC0DE0011) begin failures++; $display("FAIL err_rd_rsp got=%b/%b/%b/%h exp=1/0/0/c0de0011", bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.rsp_rdata); end
    checks++; if (bus.err_count !== 8'h01) begin failures++; $display("FAIL err_count1 got=%h exp=01", bus.err_count); end
    exp_err = 1;
    for (int k = 0; k < 260; k++) begin
      @(negedge HCLK); put_cmd(1'b1, 16'h0040, 3'd2, 32'(k)); #1;
      @(negedge HCLK); bus.cmd_valid = 1'b0; #1;
      @(negedge HCLK); bus.HREADY = 1'b0; bus.HRESP = 1'b1; #1;
      @(negedge HCLK); bus.HREADY = 1'b1; #1;
      @(negedge HCLK); bus.HRESP = 1'b0; #1;
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      checks++; if (bus.rsp_error !== 1'b1 || bus.err_count !== 8'(exp_err)) begin failures++; $display("FAIL err_sat k=%0d got=%b/%h exp=1/%h", k, bus.rsp_error, bus.err_count, 8'(exp_err)); end
    end
    checks++; if (bus.err_count !== 8'hFF) begin failures++; $display("FAIL err_sat_final got=%h exp=ff", bus.err_count); end
  endtask

  task automatic test_reset_midflight();
    @(negedge HCLK); put_cmd(1'b1, 16'h0050, 3'd2, 32'h0BADF00D); #1;
    @(negedge HCLK); put_cmd(1'b0, 16'h0054, 3'd2, 32'h0); #1;
    @(negedge HCLK); bus.cmd_valid = 1'b0; #1;
    checks++; if (bus.busy !== 1'b1 || bus.HTRANS !== HTRANS_NONSEQ) begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/10", bus.busy, bus.HTRANS); end
    HRESET = 1'b1;
    @(negedge HCLK); HRESET = 1'b0; #1;
    checks++; if (bus.HTRANS !== HTRANS_IDLE || bus.busy !== 1'b0 || bus.err_count !== 8'h00) begin failures++; $display("FAIL mid_state got=%b/%b/%h exp=00/0/00", bus.HTRANS, bus.busy, bus.err_count); end
    for (int s = 0; s < 4; s++) begin
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp cyc=%0d got=%b exp=0", s, bus.rsp_valid); end
      @(negedge HCLK); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) refmem[i] = 32'hC0DE0000 + 32'(i);
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_wdata = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_alignment();
    test_back_to_back();
    test_random();
    test_error();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
